rgb_pixel_fetch: RTL and testbench

- Downstream stage of the upsampling/colour-space-conversion block.
- Reads the packed RGB frame that block writes to SRAM and unpacks it into one 24-bit pixel per transfer, in raster order.
- Delivers pixels over a valid/ready stream to the display/output path.
- Owns the SRAM port only while Busy; the top-level mux grants the port after the conversion stage reports done.

---
 rtl/rgb_pixel_fetch.sv | 197 +++++++++++++++++++
 tb/tb_rgb_pixel_fetch.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pixel_fetch
// Purpose  : Reads the packed RGB frame from SRAM (3 words per pixel pair),
//            buffers words in a small credit-checked FIFO and unpacks them
//            into one 24-bit pixel per valid/ready transfer, in raster order.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_pixel_fetch #(
    parameter logic [17:0] RGB_BASE     = 18'd146944,
    parameter int          NUM_PIXELS   = 76800,
    parameter int          FIFO_DEPTH   = 6,
    parameter int          SRAM_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic [15:0] SRAM_write_data,
    output logic [7:0]  Pixel_R,
    output logic [7:0]  Pixel_G,
    output logic [7:0]  Pixel_B,
    output logic        Pixel_valid,
    input  logic        Pixel_ready,
    output logic        Pixel_last,
    output logic        Busy,
    output logic        Done
);

    localparam int c_WORDS_INT = 3 * NUM_PIXELS / 2;
    localparam int WC_W        = $clog2(c_WORDS_INT + 1);
    localparam int PC_W        = $clog2(NUM_PIXELS);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int IF_W        = $clog2(SRAM_LATENCY + 1);

    localparam logic [WC_W-1:0] c_WORDS    = WC_W'(c_WORDS_INT);
    localparam logic [PC_W-1:0] c_LAST_PIX = PC_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [WC_W-1:0]         r_word_cnt;
    logic [PC_W-1:0]         r_pix_cnt;
    logic [SRAM_LATENCY-1:0] r_in_flight;
    logic [15:0]             r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [CNT_W-1:0]        r_fifo_count;
    logic                    r_phase;

    logic [IF_W-1:0]         w_in_flight;
    logic                    w_issue;
    logic                    w_push;
    logic                    w_valid;
    logic                    w_accept;
    logic                    w_last;
    logic [1:0]              w_pop_cnt;
    logic [15:0]             w_head;
    logic [15:0]             w_next;

    // Circular increment; depth need not be a power of two
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign SRAM_we_n       = 1'b1;
    assign SRAM_write_data = 16'h0000;

    // Number of reads currently travelling through the SRAM pipeline
    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < SRAM_LATENCY; i++) begin
            w_in_flight = w_in_flight + IF_W'(r_in_flight[i]);
        end
    end

    // Issue only when the word is guaranteed a FIFO slot on return
    assign w_issue  = (r_state == S_FETCH) && (r_word_cnt < c_WORDS) &&
                      ((int'(r_fifo_count) + int'(w_in_flight)) < FIFO_DEPTH);
    assign w_push   = r_in_flight[SRAM_LATENCY-1];
    assign w_head   = r_fifo_mem[r_rd_ptr];
    assign w_next   = r_fifo_mem[next_ptr(r_rd_ptr)];
    assign w_valid  = (r_state == S_FETCH) && (r_fifo_count >= CNT_W'(2));
    assign w_accept = w_valid && Pixel_ready;
    assign w_last   = w_valid && (r_pix_cnt == c_LAST_PIX);

    assign Pixel_valid = w_valid;
    assign Pixel_last  = w_last;

    // Even pixel pops one word, odd pixel pops the two remaining words
    always_comb begin
        w_pop_cnt = 2'd0;
        if (w_accept) begin
            w_pop_cnt = r_phase ? 2'd2 : 2'd1;
        end
    end

    // Pixel unpack straight from the two oldest FIFO words
    always_comb begin
        Pixel_R = 8'h00;
        Pixel_G = 8'h00;
        Pixel_B = 8'h00;
        if (w_valid) begin
            if (!r_phase) begin
                Pixel_R = w_head[15:8];
                Pixel_G = w_head[7:0];
                Pixel_B = w_next[15:8];
            end else begin
                Pixel_R = w_head[7:0];
                Pixel_G = w_next[15:8];
                Pixel_B = w_next[7:0];
            end
        end
    end

    // FIFO storage; returning words land without any handshake
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= SRAM_read_data;
        end
    end

    // FIFO pointers, occupancy, unpack phase and in-flight tracker
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_in_flight  <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_fifo_count <= '0;
            r_phase      <= 1'b0;
        end else begin
            r_in_flight  <= (r_in_flight << 1) | SRAM_LATENCY'(w_issue);
            r_fifo_count <= r_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop_cnt);
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_accept) begin
                r_rd_ptr <= r_phase ? next_ptr(next_ptr(r_rd_ptr)) : next_ptr(r_rd_ptr);
                r_phase  <= ~r_phase;
            end
        end
    end

    // Frame control FSM with registered address, Busy and Done
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_word_cnt   <= '0;
            r_pix_cnt    <= '0;
            SRAM_address <= RGB_BASE;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_state    <= S_FETCH;
                        r_word_cnt <= '0;
                        r_pix_cnt  <= '0;
                        Busy       <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (w_issue) begin
                        SRAM_address <= RGB_BASE + 18'(r_word_cnt);
                        r_word_cnt   <= r_word_cnt + WC_W'(1);
                    end
                    if (w_accept) begin
                        r_pix_cnt <= r_pix_cnt + PC_W'(1);
                        if (w_last && (r_word_cnt == c_WORDS)) begin
                            r_state      <= S_DONE;
                            Done         <= 1'b1;
                            Busy         <= 1'b0;
                            SRAM_address <= RGB_BASE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgb_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_pixel_fetch
// Purpose  : Self-checking bench for rgb_pixel_fetch with an SRAM model and a
//            pixel reference model derived from the word packing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_pixel_fetch;

    localparam logic [17:0] BASE   = 18'd146944;
    localparam int          NPIX   = 96;
    localparam int          NWORDS = 3 * NPIX / 2;
    localparam int          DEPTH  = 6;
    localparam int          LAT    = 2;
    localparam int          LIMIT  = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [17:0] sram_address;
    logic [15:0] sram_read_data;
    logic        sram_we_n;
    logic [15:0] sram_write_data;
    logic [7:0]  pixel_r;
    logic [7:0]  pixel_g;
    logic [7:0]  pixel_b;
    logic        pixel_valid;
    logic        pixel_ready = 1'b0;
    logic        pixel_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [0:NWORDS-1];
    logic [15:0] sram_q = 16'h0000;
    logic [23:0] got [$];

    always #5 clk = ~clk;

    rgb_pixel_fetch #(
        .RGB_BASE     (BASE),
        .NUM_PIXELS   (NPIX),
        .FIFO_DEPTH   (DEPTH),
        .SRAM_LATENCY (LAT)
    ) dut (
        .Clock           (clk),
        .Reset           (rst),
        .Start           (start),
        .SRAM_address    (sram_address),
        .SRAM_read_data  (sram_read_data),
        .SRAM_we_n       (sram_we_n),
        .SRAM_write_data (sram_write_data),
        .Pixel_R         (pixel_r),
        .Pixel_G         (pixel_g),
        .Pixel_B         (pixel_b),
        .Pixel_valid     (pixel_valid),
        .Pixel_ready     (pixel_ready),
        .Pixel_last      (pixel_last),
        .Busy            (busy),
        .Done            (done)
    );

    function automatic logic [15:0] sram_lookup(input logic [17:0] a);
        int idx;
        idx = int'(a) - int'(BASE);
        if (idx >= 0 && idx < NWORDS) return mem[idx];
        return 16'hDEAD;
    endfunction

    // Synchronous SRAM: data for the address seen this cycle appears next cycle
    always @(posedge clk) sram_q <= sram_lookup(sram_address);
    assign sram_read_data = sram_q;

    // Pixel i from the packing rule: pair k lives in words 3k..3k+2
    function automatic logic [23:0] model_pixel(input int i);
        int k;
        logic [15:0] a, b, c;
        if (i < 0 || i >= NPIX) return 'x;
        k = i / 2;
        a = mem[3*k];
        b = mem[3*k+1];
        c = mem[3*k+2];
        if (i % 2 == 0) return {a, b[15:8]};
        return {b[7:0], c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input bit fixed_head);
        for (int i = 0; i < NWORDS; i++) mem[i] = 16'($urandom);
        if (fixed_head) begin
            mem[0] = 16'h1020; mem[1] = 16'h3040; mem[2] = 16'h5060;
            mem[3] = 16'h7080; mem[4] = 16'h90A0; mem[5] = 16'hB0C0;
        end
    endtask

    task automatic check_reset_values();
        check("rst_addr",  32'(sram_address), 32'(BASE));
        check("rst_valid", 32'(pixel_valid), 0);
        check("rst_last",  32'(pixel_last), 0);
        check("rst_rgb",   32'({pixel_r, pixel_g, pixel_b}), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_we_n",  32'(sram_we_n), 1);
        check("rst_wdata", 32'(sram_write_data), 0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // One frame: mode 0 = ready held high, mode 1 = 50% random ready.
    // Ready is forced low in cycles stall_lo..stall_hi (counted from the Start cycle).
    task automatic run_frame(input int mode, input int stall_lo, input int stall_hi,
                             input int start_at, input int reset_at);
        int          cyc = 0;
        int          pix = 0;
        int          done_cnt = 0;
        int          first_valid = -1;
        int          last_acc = -1;
        int          addr_bad = 0;
        int          stable_bad = 0;
        int          we_bad = 0;
        int          tail = 0;
        logic [17:0] prev_addr = BASE;
        logic [17:0] fetch_addr = BASE;
        bit          prev_stall = 1'b0;
        logic [23:0] prev_px = '0;
        logic        prev_last = 1'b0;
        logic [23:0] px;
        bit          acc;
        bit          finished = 1'b0;
        bit          aborted = 1'b0;

        got.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!finished && cyc < LIMIT) begin
            px = {pixel_r, pixel_g, pixel_b};
            if (sram_we_n !== 1'b1 || sram_write_data !== 16'h0000) we_bad++;
            if (busy && sram_address !== prev_addr && sram_address !== prev_addr + 18'd1) addr_bad++;
            if (busy) fetch_addr = sram_address;
            prev_addr = sram_address;
            if (pixel_valid && first_valid < 0) first_valid = cyc;
            if (prev_stall && (pixel_valid !== 1'b1 || px !== prev_px || pixel_last !== prev_last))
                stable_bad++;
            if (cyc == stall_hi)
                check("stall_credit", 32'(sram_address - BASE) + 1, 3*(pix/2) + pix%2 + DEPTH);
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    check("done_after_last", cyc, last_acc + 1);
                    check("done_busy", 32'(busy), 0);
                    check("done_addr", 32'(sram_address), 32'(BASE));
                end
            end

            if (cyc == reset_at) begin
                pixel_ready = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_reset_values();
                check("first_valid", first_valid, 5);
                finished = 1'b1;
                aborted = 1'b1;
            end else begin
                if (cyc == start_at) begin
                    check("start_mid_busy", 32'(busy), 1);
                    start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                if (cyc >= stall_lo && cyc <= stall_hi) pixel_ready = 1'b0;
                else if (mode == 1) pixel_ready = 1'($urandom & 1);
                else pixel_ready = 1'b1;
                acc = pixel_valid && pixel_ready;
                if (acc) begin
                    check("pixel", 32'(px), 32'(model_pixel(pix)));
                    check("last", 32'(pixel_last), 32'(pix == NPIX - 1));
                    got.push_back(px);
                    last_acc = cyc;
                    pix++;
                end
                prev_stall = pixel_valid && !pixel_ready;
                prev_px = px;
                prev_last = pixel_last;
                if (done_cnt > 0) tail++;
                if (tail > 12) finished = 1'b1;
                else begin
                    @(posedge clk); #1;
                    cyc++;
                end
            end
        end
        start = 1'b0;
        pixel_ready = 1'b0;
        if (!aborted) begin
            check("frame_complete", done_cnt, 1);
            check("pixel_count", pix, NPIX);
            check("first_valid", first_valid, 5);
            check("reads_issued", 32'(fetch_addr - BASE) + 1, NWORDS);
            check("addr_seq", addr_bad, 0);
            check("stable", stable_bad, 0);
            check("we_n_const", we_bad, 0);
            check("idle_at_end", 32'(busy), 0);
        end
    endtask

    initial begin
        logic [23:0] first4 [4];
        first4[0] = 24'h102030;
        first4[1] = 24'h405060;
        first4[2] = 24'h708090;
        first4[3] = 24'hA0B0C0;

        // Reset state
        rst = 1'b1;
        idle_cycles(3);
        check_reset_values();
        rst = 1'b0;
        idle_cycles(2);

        // First pixels and end of frame, ready held high
        fill_mem(1'b1);
        run_frame(0, -1, -1, -1, -1);
        for (int i = 0; i < 4; i++) check("first_pixels", 32'(got[i]), 32'(first4[i]));
        idle_cycles(3);

        // Backpressure window in cycles 10..29
        fill_mem(1'b0);
        run_frame(0, 10, 29, -1, -1);
        idle_cycles(3);

        // Random ready
        fill_mem(1'b0);
        run_frame(1, -1, -1, -1, -1);
        idle_cycles(3);

        // Start pulse mid-frame must be ignored
        fill_mem(1'b0);
        run_frame(1, -1, -1, 100, -1);
        idle_cycles(3);

        // Reset mid-frame, then a clean frame starting right away
        fill_mem(1'b0);
        run_frame(1, -1, -1, -1, 50);
        fill_mem(1'b0);
        run_frame(0, -1, -1, -1, -1);
        idle_cycles(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
